// File: rtl/stack_pkg.sv
// Shared definitions for the stack_ring_param stack core.
//   stack_cmd_t : 2-bit command encoding (NOP/PUSH/POP/GET)
//   idx_w()     : width of a slot pointer / GET index for a given depth
//   cnt_w()     : width of an occupancy counter able to hold 0..depth
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } stack_cmd_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ring_index_step.sv
// Modulo-DEPTH pointer step: result = (ptr +/- offset) mod DEPTH.
//   ptr    : current pointer, expected in 0..DEPTH-1
//   offset : step size; values >= DEPTH are folded once
//   dir    : 0 = add, 1 = subtract
//   result : wrapped pointer, always in 0..DEPTH-1
// DEPTH need not be a power of two, so the wrap is an explicit compare
// and correct rather than a bit truncation.
module ring_index_step
  import stack_pkg::*;
#(
  parameter  int unsigned DEPTH = 5,
  localparam int unsigned PW    = idx_w(DEPTH)
) (
  input  logic [PW-1:0] ptr,
  input  logic [PW-1:0] offset,
  input  logic          dir,
  output logic [PW-1:0] result
);

  localparam logic [PW:0] DEPTH_X = (PW+1)'(DEPTH);

  logic [PW:0] ptr_x;
  logic [PW:0] off_x;
  logic [PW:0] sum_x;

  always_comb begin
    ptr_x = {1'b0, ptr};
    off_x = {1'b0, offset};
    // An index field wider than the ring can exceed DEPTH-1; one fold is
    // enough because 2^PW < 2*DEPTH.
    if (off_x >= DEPTH_X) begin
      off_x = off_x - DEPTH_X;
    end
    if (!dir) begin
      sum_x = ptr_x + off_x;
      if (sum_x >= DEPTH_X) begin
        sum_x = sum_x - DEPTH_X;
      end
    end else begin
      if (ptr_x >= off_x) begin
        sum_x = ptr_x - off_x;
      end else begin
        sum_x = ptr_x + DEPTH_X - off_x;
      end
    end
    result = sum_x[PW-1:0];
  end

endmodule

// File: rtl/stack_ring_param.sv
// Parametrised circular LIFO stack with valid/ready command port and a
// registered, back-pressurable read port.
//   CLK, RESET           : clock (rising edge), synchronous active-low reset
//   CMD, CMD_VALID       : command (NOP/PUSH/POP/GET) and its valid
//   CMD_READY            : command accepted at the edge when valid && ready
//   INDEX                : GET depth, 0 = top of stack
//   I_DATA               : PUSH data
//   O_DATA, O_VALID      : POP/GET result register and its valid
//   O_READY              : consumer takes O_DATA when O_VALID && O_READY
//   ERR                  : one-cycle pulse for each rejected command
//   COUNT, FULL, EMPTY   : occupancy status
// OVERWRITE=1 lets a PUSH on a full stack replace the oldest entry (the
// slot TOP points at); OVERWRITE=0 rejects it.
module stack_ring_param
  import stack_pkg::*;
#(
  parameter  int unsigned WIDTH     = 4,
  parameter  int unsigned DEPTH     = 5,
  parameter  bit          OVERWRITE = 1'b1,
  localparam int unsigned IW        = idx_w(DEPTH),
  localparam int unsigned CW        = cnt_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       CMD,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [IW-1:0]    INDEX,
  input  logic [WIDTH-1:0] I_DATA,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             ERR,
  output logic [CW-1:0]    COUNT,
  output logic             FULL,
  output logic             EMPTY
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] ONE_I   = IW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    top;
  logic [CW-1:0]    count;

  logic [IW-1:0]    top_inc;
  logic [IW-1:0]    top_dec;
  logic [IW-1:0]    rd_addr;

  stack_cmd_t       cmd;
  logic             accept;
  logic             mem_we;
  logic             load;
  logic             reject;
  logic [IW-1:0]    load_addr;
  logic [IW-1:0]    top_nxt;
  logic [CW-1:0]    count_nxt;

  assign cmd       = stack_cmd_t'(CMD);
  assign CMD_READY = !O_VALID || O_READY;
  assign accept    = CMD_VALID && CMD_READY;
  assign COUNT     = count;
  assign FULL      = (count == DEPTH_C);
  assign EMPTY     = (count == '0);

  ring_index_step #(.DEPTH(DEPTH)) u_top_inc (
    .ptr    (top),
    .offset (ONE_I),
    .dir    (1'b0),
    .result (top_inc)
  );

  ring_index_step #(.DEPTH(DEPTH)) u_top_dec (
    .ptr    (top),
    .offset (ONE_I),
    .dir    (1'b1),
    .result (top_dec)
  );

  // GET address TOP-1-INDEX, built from the already-wrapped TOP-1 so the
  // offset never needs an extra bit for INDEX+1.
  ring_index_step #(.DEPTH(DEPTH)) u_rd_addr (
    .ptr    (top_dec),
    .offset (INDEX),
    .dir    (1'b1),
    .result (rd_addr)
  );

  always_comb begin
    mem_we    = 1'b0;
    load      = 1'b0;
    reject    = 1'b0;
    load_addr = top_dec;
    top_nxt   = top;
    count_nxt = count;
    if (accept) begin
      unique case (cmd)
        CMD_PUSH: begin
          if (!FULL || OVERWRITE) begin
            mem_we  = 1'b1;
            top_nxt = top_inc;
            if (!FULL) begin
              count_nxt = count + CW'(1);
            end
          end else begin
            reject = 1'b1;
          end
        end
        CMD_POP: begin
          if (!EMPTY) begin
            load      = 1'b1;
            load_addr = top_dec;
            top_nxt   = top_dec;
            count_nxt = count - CW'(1);
          end else begin
            reject = 1'b1;
          end
        end
        CMD_GET: begin
          if (32'(INDEX) < 32'(count)) begin
            load      = 1'b1;
            load_addr = rd_addr;
          end else begin
            reject = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      top     <= '0;
      count   <= '0;
      O_VALID <= 1'b0;
      O_DATA  <= '0;
      ERR     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      top   <= top_nxt;
      count <= count_nxt;
      ERR   <= reject;
      if (mem_we) begin
        mem[top] <= I_DATA;
      end
      // A new result replaces the old one in the same cycle it is taken,
      // so back-to-back POP/GET produce no bubble.
      if (load) begin
        O_DATA  <= mem[load_addr];
        O_VALID <= 1'b1;
      end else if (O_VALID && O_READY) begin
        O_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stack_ring_param.sv
// Directed bench for stack_ring_param with an output scoreboard.
// Two instances share stimulus: dut_a (OVERWRITE=1) and dut_b (OVERWRITE=0);
// sel chooses which one the checks observe.
module tb_stack_ring_param;
  import stack_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned IW    = 3;
  localparam int unsigned CW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       cmd;
  logic             cmd_valid;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             sel;

  logic             a_cmd_ready, a_o_valid, a_err, a_full, a_empty;
  logic [WIDTH-1:0] a_o_data;
  logic [CW-1:0]    a_count;
  logic             b_cmd_ready, b_o_valid, b_err, b_full, b_empty;
  logic [WIDTH-1:0] b_o_data;
  logic [CW-1:0]    b_count;

  logic             s_cmd_ready, s_o_valid, s_err, s_full, s_empty;
  logic [WIDTH-1:0] s_o_data;
  logic [CW-1:0]    s_count;

  stack_ring_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(1'b1)) dut_a (
    .CLK(clk), .RESET(rst_n), .CMD(cmd), .CMD_VALID(cmd_valid),
    .CMD_READY(a_cmd_ready), .INDEX(index), .I_DATA(i_data),
    .O_DATA(a_o_data), .O_VALID(a_o_valid), .O_READY(o_ready),
    .ERR(a_err), .COUNT(a_count), .FULL(a_full), .EMPTY(a_empty)
  );

  stack_ring_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(1'b0)) dut_b (
    .CLK(clk), .RESET(rst_n), .CMD(cmd), .CMD_VALID(cmd_valid),
    .CMD_READY(b_cmd_ready), .INDEX(index), .I_DATA(i_data),
    .O_DATA(b_o_data), .O_VALID(b_o_valid), .O_READY(o_ready),
    .ERR(b_err), .COUNT(b_count), .FULL(b_full), .EMPTY(b_empty)
  );

  always_comb begin
    if (sel) begin
      s_cmd_ready = b_cmd_ready; s_o_valid = b_o_valid; s_err = b_err;
      s_full = b_full; s_empty = b_empty; s_o_data = b_o_data; s_count = b_count;
    end else begin
      s_cmd_ready = a_cmd_ready; s_o_valid = a_o_valid; s_err = a_err;
      s_full = a_full; s_empty = a_empty; s_o_data = a_o_data; s_count = a_count;
    end
  end

  int n_vec  = 0;
  int n_miss = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] mon_exp;

  // Output monitor: every output handshake consumes one expected value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && s_o_valid === 1'b1 && o_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL o_data_unexpected: got %0d, expected no output", s_o_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (s_o_data !== mon_exp) begin
          n_miss++;
          $display("FAIL o_data: got %0d, expected %0d", s_o_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one command and returns #1 after the edge that accepted it.
  task automatic issue(input logic [1:0] c, input logic [IW-1:0] idx, input logic [WIDTH-1:0] d);
    bit ok;
    cmd = c; index = idx; i_data = d; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL cmd_ready_timeout: got 0, expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd = CMD_NOP;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    issue(CMD_PUSH, '0, d);
  endtask

  task automatic pop_exp(input logic [WIDTH-1:0] e);
    exp_q.push_back(e);
    issue(CMD_POP, '0, '0);
  endtask

  task automatic get_exp(input logic [IW-1:0] idx, input logic [WIDTH-1:0] e);
    exp_q.push_back(e);
    issue(CMD_GET, idx, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd = CMD_NOP; cmd_valid = 1'b0; index = '0;
    i_data = '0; o_ready = 1'b1; sel = 1'b0;
    do_reset();
    check("rst_count", s_count, 0);
    check("rst_empty", s_empty, 1);
    check("rst_full", s_full, 0);
    check("rst_o_valid", s_o_valid, 0);
    check("rst_o_data", s_o_data, 0);
    check("rst_err", s_err, 0);
    check("rst_cmd_ready", s_cmd_ready, 1);

    // PUSH 3,7,9 then GETs
    push(4'd3); push(4'd7); push(4'd9);
    check("p3_count", s_count, 3);
    get_exp(3'd0, 4'd9);
    check("get0_valid", s_o_valid, 1);
    get_exp(3'd2, 4'd3);
    issue(CMD_GET, 3'd3, '0);
    check("get3_err", s_err, 1);
    check("get3_o_valid", s_o_valid, 0);
    check("get3_count", s_count, 3);
    idle(1);
    check("get3_err_pulse", s_err, 0);

    // POP on empty
    do_reset();
    issue(CMD_POP, '0, '0);
    check("pop_empty_err", s_err, 1);
    check("pop_empty_count", s_count, 0);
    check("pop_empty_empty", s_empty, 1);
    check("pop_empty_o_valid", s_o_valid, 0);
    idle(1);
    check("pop_empty_err_pulse", s_err, 0);

    // Overwrite mode: six pushes into five slots
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      push(WIDTH'(i));
      check("ow_push_err", s_err, 0);
    end
    check("ow_count", s_count, 5);
    check("ow_full", s_full, 1);
    for (int i = 6; i >= 2; i--) begin
      pop_exp(WIDTH'(i));
      check("ow_pop_err", s_err, 0);
    end
    check("ow_empty", s_empty, 1);
    issue(CMD_POP, '0, '0);
    check("ow_pop6_err", s_err, 1);
    check("ow_pop6_o_valid", s_o_valid, 0);

    // Reject mode
    sel = 1'b1;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      push(WIDTH'(i));
      check("rj_push_err", s_err, 0);
    end
    push(4'd6);
    check("rj_push6_err", s_err, 1);
    check("rj_count", s_count, 5);
    check("rj_full", s_full, 1);
    pop_exp(4'd5);
    check("rj_pop_count", s_count, 4);
    idle(1);
    check("rj_o_valid_clear", s_o_valid, 0);
    sel = 1'b0;

    // Back-pressure with stack holding 1,2
    do_reset();
    push(4'd1); push(4'd2);
    o_ready = 1'b0;
    pop_exp(4'd2);
    cmd = CMD_POP; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("bp_cmd_ready", s_cmd_ready, 0);
      check("bp_o_valid", s_o_valid, 1);
      check("bp_o_data", s_o_data, 2);
      check("bp_count", s_count, 1);
    end
    o_ready = 1'b1;
    exp_q.push_back(4'd1);
    idle(1);
    cmd_valid = 1'b0; cmd = CMD_NOP;
    check("bp_next_o_valid", s_o_valid, 1);
    check("bp_next_o_data", s_o_data, 1);
    check("bp_next_count", s_count, 0);
    idle(1);
    check("bp_drain_o_valid", s_o_valid, 0);

    // Reset drops a pending output
    push(4'd5);
    o_ready = 1'b0;
    pop_exp(4'd5);
    idle(1);
    check("hold_o_valid", s_o_valid, 1);
    do_reset();
    check("rst2_o_valid", s_o_valid, 0);
    check("rst2_count", s_count, 0);
    check("rst2_o_data", s_o_data, 0);
    check("rst2_err", s_err, 0);
    o_ready = 1'b1;
    issue(CMD_GET, 3'd0, '0);
    check("rst2_get_err", s_err, 1);
    check("rst2_get_o_valid", s_o_valid, 0);

    idle(2);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stack_ring_param.md
# stack_ring_param

Parametrised circular LIFO stack: WIDTH-bit entries, DEPTH slots, PUSH/POP/GET commands with a valid/ready command handshake and a registered, back-pressurable read port. Next-generation stack core, replacing the fixed 5×4 bidirectional-bus stack. Split input and output data buses, so no tristate. Selectable overwrite-on-full or reject-on-full mode, plus full/empty/count status and an error pulse.

## Interface
- WIDTH, 4: data bits per entry (≥1)
- DEPTH, 5: number of slots (≥2, any value, not restricted to powers of 2)
- OVERWRITE, 1: 1 = PUSH when full overwrites the oldest entry (ring); 0 = PUSH when full is rejected with ERR
- CLK  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-low reset
- CMD  in  2  00 NOP, 01 PUSH, 10 POP, 11 GET
- CMD_VALID  in  1  command present
- CMD_READY  out  1  command accepted on CLK edge when CMD_VALID && CMD_READY
- INDEX  in  IW=$clog2(DEPTH)  GET depth (0 = top of stack)
- I_DATA  in  WIDTH  PUSH data
- O_DATA  out  WIDTH  POP/GET result, registered
- O_VALID  out  1  O_DATA valid
- O_READY  in  1  consumer takes O_DATA when O_VALID && O_READY
- ERR  out  1  one-cycle pulse on rejected command
- COUNT  out  CW=$clog2(DEPTH+1)  entries held, 0..DEPTH
- FULL / EMPTY  out  1 each  COUNT==DEPTH / COUNT==0, combinational from COUNT

## Operation
- State: mem[DEPTH], TOP (next write slot, 0..DEPTH-1), COUNT, output register.
- All pointer arithmetic is modulo DEPTH with explicit wrap:
  - DEPTH-1 increments to 0.
  - 0 decrements to DEPTH-1.
- CMD_READY = !O_VALID || O_READY, independent of CMD.
- A NOP is accepted with no effect.
- PUSH:
  - COUNT<DEPTH: mem[TOP]<=I_DATA; TOP<=TOP+1; COUNT+1.
  - Full and OVERWRITE=1: same write and TOP advance; COUNT stays DEPTH. The oldest entry is lost.
  - Full and OVERWRITE=0: no write; ERR=1.
- POP:
  - COUNT>0: O_DATA<=mem[TOP-1]; TOP<=TOP-1; COUNT-1; O_VALID<=1.
  - Empty: ERR=1; state unchanged.
- GET:
  - INDEX<COUNT: O_DATA<=mem[TOP-1-INDEX]; O_VALID<=1; TOP and COUNT unchanged.
  - INDEX≥COUNT: ERR=1; O_VALID is not set.
- O_VALID:
  - Clears on a handshake when no new POP/GET is accepted in the same cycle.
  - Otherwise holds, and O_DATA stays stable while O_VALID && !O_READY.
- Rejected commands are still consumed (the handshake completes) and are never retried.

## Timing
- Reset (RESET low at an edge) takes priority over any accepted command. Values after that edge:
  - TOP=0, COUNT=0, O_VALID=0, O_DATA=0, ERR=0.
  - All mem entries 0.
  - A pending output is dropped.
- Latency: POP/GET accepted at edge N gives O_VALID/O_DATA after edge N.
- Status after edge N: ERR, COUNT, FULL and EMPTY reflect the command accepted at edge N.
- Throughput: one command per cycle while O_READY=1.
- Output handshake at edge N together with a new POP/GET: O_VALID stays 1 and O_DATA carries the new result, with no bubble.
- PUSH accepted while O_VALID=1 and O_READY=1: O_VALID falls after the edge.
- ERR is high for exactly one cycle per rejected command.

## Structure
- Shared package stack_pkg:
  - Command encoding constants CMD_NOP, CMD_PUSH, CMD_POP, CMD_GET.
  - Type stack_cmd_t (2-bit).
  - Width helpers for IW and CW.
- Sub-module ring_index_step (parameter DEPTH): inputs pointer, offset and direction; output is the pointer ± offset mod DEPTH.
  - Used for the TOP update.
  - Used for the read address TOP-1-INDEX.
- Memory is flop-based and written only on an accepted PUSH.

## Test plan
- Defaults, reset, PUSH 3, 7, 9 → COUNT=3. GET 0 → O_DATA=9. GET 2 → 3. GET 3 → ERR pulse, O_VALID=0, COUNT stays 3.
- After reset, POP → ERR for one cycle, COUNT=0, EMPTY=1, O_VALID=0.
- OVERWRITE=1, PUSH 1..6 → COUNT=5, FULL=1, no ERR. Five POPs return 6, 5, 4, 3, 2. Sixth POP → ERR.
- OVERWRITE=0, PUSH 1..6 → ERR on the sixth PUSH, COUNT=5. POP → 5.
- Back-pressure, with stack holding 1, 2 (top 2):
  - POP with O_READY=0 for 3 cycles → O_VALID=1 and O_DATA=2 held, CMD_READY=0, COUNT=1.
  - Raise O_READY together with a POP → next cycle O_DATA=1, O_VALID=1, COUNT=0.
- Hold O_VALID=1 (O_READY=0), then drive RESET low for one edge → O_VALID=0, COUNT=0, O_DATA=0. Subsequent GET 0 → ERR.
